// File: rtl/pad_attr_regfile.sv
// Run-time pad attribute register file.
// One WARL-masked attribute word per pad, a sticky per-pad write lock,
// an optional shadow copy that reaches the pad ring only on commit, and a
// single-outstanding request/response port with a fixed one-cycle latency.
//
// Handshake: a request is accepted on a rising edge where req_i and gnt_o are
// both high. The response (rvalid_o with rdata_o/err_o) is present for exactly
// the following cycle, during which gnt_o is low. A requester seeing gnt_o low
// holds req_i and its payload stable until gnt_o returns high.
module pad_attr_regfile #(
  parameter int                   NumPads      = 4,
  parameter int                   AttrDw       = 32,
  parameter logic [NumPads*3-1:0] PadTypes     = '0,
  parameter bit                   ShadowUpdate = 1'b0,
  parameter int                   AddrW        = $clog2(2*NumPads)+1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [AddrW-1:0]          addr_i,
  input  logic [AttrDw-1:0]         wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [AttrDw-1:0]         rdata_o,
  output logic                      err_o,
  input  logic                      commit_i,
  output logic [NumPads*AttrDw-1:0] attr_o,
  output logic                      dbg_state_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Legal bits for a pad type; everything outside the mask reads back as 0.
  function automatic logic [AttrDw-1:0] type_mask(input logic [2:0] t);
    logic [AttrDw-1:0] m;
    m = '0;
    case (t)
      3'd0: m[9:0] = '1;
      3'd1: begin
        m[0] = 1'b1;
        m[2] = 1'b1;
        m[3] = 1'b1;
        m[5] = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

  state_e               r_state;
  logic                 r_gnt;
  logic                 r_rvalid;
  logic [AttrDw-1:0]    r_rdata;
  logic                 r_err;
  logic [AttrDw-1:0]    r_store  [NumPads];
  logic [NumPads-1:0]   r_regwen;

  logic [AttrDw-1:0]    w_mask       [NumPads];
  logic [AttrDw-1:0]    w_store_next [NumPads];
  logic [AttrDw-1:0]    w_live       [NumPads];
  logic [NumPads-1:0]   w_sel_attr;
  logic [NumPads-1:0]   w_sel_rwen;
  logic                 w_err;
  logic                 w_accept;
  logic [AttrDw-1:0]    w_rd;

  assign w_accept    = (r_state == ST_IDLE) && req_i;
  assign gnt_o       = r_gnt;
  assign rvalid_o    = r_rvalid;
  assign rdata_o     = r_rdata;
  assign err_o       = r_err;
  assign dbg_state_o = (r_state == ST_RESP);

  // Per-pad WARL masks from the static type table.
  always_comb begin
    for (int i = 0; i < NumPads; i++) begin
      w_mask[i] = type_mask(PadTypes[3*i +: 3]);
    end
  end

  // Address decode: attribute words first, then the regwen words, rest error.
  always_comb begin
    w_sel_attr = '0;
    w_sel_rwen = '0;
    for (int i = 0; i < NumPads; i++) begin
      if (addr_i == AddrW'(i))           w_sel_attr[i] = 1'b1;
      if (addr_i == AddrW'(NumPads + i)) w_sel_rwen[i] = 1'b1;
    end
    w_err = ~(|w_sel_attr) & ~(|w_sel_rwen);
  end

  // Read mux over stored words (shadow words in shadow mode) and regwen bits.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NumPads; i++) begin
      if (w_sel_attr[i]) w_rd = r_store[i];
      if (w_sel_rwen[i]) w_rd = AttrDw'(r_regwen[i]);
    end
  end

  // Next stored words: a granted write to an unlocked pad lands masked.
  always_comb begin
    for (int i = 0; i < NumPads; i++) begin
      w_store_next[i] = r_store[i];
      if (w_accept && we_i && w_sel_attr[i] && r_regwen[i]) begin
        w_store_next[i] = wdata_i & w_mask[i];
      end
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 1'b1;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_state  <= ST_RESP;
            r_gnt    <= 1'b0;
            r_rvalid <= 1'b1;
            r_err    <= w_err;
            r_rdata  <= (we_i || w_err) ? '0 : w_rd;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_gnt    <= 1'b1;
          r_rvalid <= 1'b0;
          r_rdata  <= '0;
          r_err    <= 1'b0;
        end
      endcase
    end
  end

  // Stored words and sticky write-0-to-clear locks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumPads; i++) r_store[i] <= '0;
      r_regwen <= '1;
    end else begin
      for (int i = 0; i < NumPads; i++) begin
        r_store[i] <= w_store_next[i];
        if (w_accept && we_i && w_sel_rwen[i] && !wdata_i[0]) begin
          r_regwen[i] <= 1'b0;
        end
      end
    end
  end

  generate
    if (ShadowUpdate) begin : g_shadow
      logic [AttrDw-1:0] r_live [NumPads];

      // Commit copies the post-write shadow so a coincident write is included.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < NumPads; i++) r_live[i] <= '0;
        end else if (commit_i) begin
          for (int i = 0; i < NumPads; i++) r_live[i] <= w_store_next[i];
        end
      end

      // Pad ring sees the committed copy.
      always_comb begin
        for (int i = 0; i < NumPads; i++) w_live[i] = r_live[i];
      end
    end else begin : g_direct
      logic w_unused_commit;
      assign w_unused_commit = commit_i;

      // Pad ring sees the stored words directly.
      always_comb begin
        for (int i = 0; i < NumPads; i++) w_live[i] = r_store[i];
      end
    end
  endgenerate

  // Pack live words onto the pad attribute bus.
  always_comb begin
    attr_o = '0;
    for (int i = 0; i < NumPads; i++) begin
      attr_o[AttrDw*i +: AttrDw] = w_live[i];
    end
  end

endmodule

// File: tb/tb_pad_attr_regfile.sv
// Directed bench: a direct-mode and a shadow-mode instance share every input,
// so their handshakes and readback agree while their attr_o buses differ.
module tb_pad_attr_regfile;

  localparam int          NP  = 4;
  localparam int          DW  = 32;
  localparam int          AW  = 4;
  localparam logic [11:0] PT  = {3'd2, 3'd1, 3'd0, 3'd0};

  logic           clk;
  logic           rst_n;
  logic           req;
  logic           we;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  wdata;
  logic           commit;

  logic           gnt0, gnt1, rvalid0, rvalid1, err0, err1, dbg0, dbg1;
  logic [DW-1:0]  rdata0, rdata1;
  logic [127:0]   attr0, attr1;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0]  rd0, rd1;
  logic           er0, er1;
  logic [127:0]   at0, at1;
  logic [127:0]   exp_attr;

  pad_attr_regfile #(.NumPads(NP), .AttrDw(DW), .PadTypes(PT), .ShadowUpdate(1'b0)) u_direct (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0),
    .commit_i(commit), .attr_o(attr0), .dbg_state_o(dbg0)
  );

  pad_attr_regfile #(.NumPads(NP), .AttrDw(DW), .PadTypes(PT), .ShadowUpdate(1'b1)) u_shadow (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1),
    .commit_i(commit), .attr_o(attr1), .dbg_state_o(dbg1)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request through the port; captures both instances' response cycle.
  task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic cm);
    int n;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; commit = cm;
    n = 0;
    while (gnt0 !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk1("gnt_before_accept", gnt0, 1'b1);
    @(posedge clk);
    #1;
    req = 1'b0; commit = 1'b0;
    chk1("rvalid_resp_direct", rvalid0, 1'b1);
    chk1("rvalid_resp_shadow", rvalid1, 1'b1);
    chk1("gnt_low_in_resp", gnt0, 1'b0);
    rd0 = rdata0; rd1 = rdata1; er0 = err0; er1 = err1; at0 = attr0; at1 = attr1;
    @(posedge clk);
    #1;
    chk1("rvalid_one_cycle", rvalid0, 1'b0);
    chk1("gnt_back_idle", gnt0, 1'b1);
  endtask

  task automatic commit_pulse();
    @(negedge clk);
    commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; commit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    chk1("rst_gnt", gnt0, 1'b1);
    chk1("rst_rvalid", rvalid0, 1'b0);
    chk32("rst_rdata", rdata0, 32'h0);
    chk1("rst_err", err0, 1'b0);
    chk128("rst_attr_direct", attr0, 128'h0);
    chk128("rst_attr_shadow", attr1, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read every mapped address after reset
    for (int a = 0; a < 2*NP; a++) begin
      access(1'b0, AW'(a), 32'h0, 1'b0);
      chk32("rd_after_rst", rd0, (a < NP) ? 32'h0 : 32'h1);
      chk32("rd_after_rst_shadow", rd1, (a < NP) ? 32'h0 : 32'h1);
      chk1("rd_after_rst_err", er0, 1'b0);
    end

    // WARL masking per pad type; direct attr visible in the response cycle
    access(1'b1, 4'd0, 32'hFFFF_FFFF, 1'b0);
    chk32("wr_rdata_zero", rd0, 32'h0);
    chk1("wr_err_zero", er0, 1'b0);
    chk32("attr_pad0_resp_cycle", at0[31:0], 32'h3FF);
    access(1'b1, 4'd1, 32'hFFFF_FFFF, 1'b0);
    chk32("attr_pad1_resp_cycle", at0[63:32], 32'h3FF);
    access(1'b1, 4'd2, 32'hFFFF_FFFF, 1'b0);
    access(1'b1, 4'd3, 32'hFFFF_FFFF, 1'b0);
    access(1'b0, 4'd0, 32'h0, 1'b0); chk32("rb_pad0_bidir", rd0, 32'h3FF);
    access(1'b0, 4'd1, 32'h0, 1'b0); chk32("rb_pad1_bidir", rd0, 32'h3FF);
    access(1'b0, 4'd2, 32'h0, 1'b0); chk32("rb_pad2_input", rd0, 32'h02D);
    chk32("rb_pad2_shadow", rd1, 32'h02D);
    access(1'b0, 4'd3, 32'h0, 1'b0); chk32("rb_pad3_analog", rd0, 32'h0);
    chk128("attr_direct_all", attr0, {32'h0, 32'h2D, 32'h3FF, 32'h3FF});
    chk128("attr_shadow_uncommitted", attr1, 128'h0);

    // Shadow write stays hidden until commit
    access(1'b1, 4'd0, 32'h0000_0081, 1'b0);
    chk128("shadow_hidden_resp", at1, 128'h0);
    chk32("direct_pad0_081", at0[31:0], 32'h081);
    commit_pulse();
    chk128("shadow_after_commit", attr1, {32'h0, 32'h2D, 32'h3FF, 32'h081});
    // Write coincident with commit is part of the copy
    access(1'b1, 4'd1, 32'h0000_0155, 1'b1);
    chk128("shadow_write_with_commit", at1, {32'h0, 32'h2D, 32'h155, 32'h081});

    // Lock pad 1 and confirm writes are dropped without error
    access(1'b1, 4'd5, 32'h0, 1'b0);
    chk1("lock_wr_err", er0, 1'b0);
    access(1'b0, 4'd5, 32'h0, 1'b0); chk32("regwen1_cleared", rd0, 32'h0);
    access(1'b0, 4'd4, 32'h0, 1'b0); chk32("regwen0_still_set", rd0, 32'h1);
    access(1'b1, 4'd1, 32'h0000_0003, 1'b0);
    chk1("locked_wr_err", er0, 1'b0);
    chk32("locked_wr_rdata", rd0, 32'h0);
    access(1'b0, 4'd1, 32'h0, 1'b0); chk32("locked_pad1_unchanged", rd0, 32'h155);
    chk32("locked_pad1_shadow_unchanged", rd1, 32'h155);
    access(1'b1, 4'd5, 32'h1, 1'b0);
    access(1'b0, 4'd5, 32'h0, 1'b0); chk32("regwen1_sticky", rd0, 32'h0);

    // Out-of-range accesses
    access(1'b0, 4'd8, 32'h0, 1'b0);
    chk1("oor8_rd_err", er0, 1'b1);
    chk32("oor8_rd_rdata", rd0, 32'h0);
    access(1'b0, 4'd15, 32'h0, 1'b0);
    chk1("oor15_rd_err", er1, 1'b1);
    access(1'b1, 4'd8, 32'hFFFF_FFFE, 1'b0);
    chk1("oor8_wr_err", er0, 1'b1);
    chk32("oor8_wr_rdata", rd0, 32'h0);
    exp_attr = {32'h0, 32'h2D, 32'h155, 32'h081};
    chk128("oor_wr_attr_direct", attr0, exp_attr);
    chk128("oor_wr_attr_shadow", attr1, exp_attr);
    access(1'b0, 4'd0, 32'h0, 1'b0); chk32("oor_wr_pad0_kept", rd0, 32'h081);
    access(1'b0, 4'd4, 32'h0, 1'b0); chk32("oor_wr_regwen0_kept", rd0, 32'h1);

    // Back-to-back: second request waits out the response cycle
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 4'd2;
    @(posedge clk);
    #1;
    chk1("b2b_first_rvalid", rvalid0, 1'b1);
    chk32("b2b_first_rdata", rdata0, 32'h02D);
    chk1("b2b_gnt_low", gnt0, 1'b0);
    addr = 4'd0;
    @(posedge clk);
    #1;
    chk1("b2b_gap_rvalid", rvalid0, 1'b0);
    chk1("b2b_gap_gnt", gnt0, 1'b1);
    @(posedge clk);
    #1;
    req = 1'b0;
    chk1("b2b_second_rvalid", rvalid0, 1'b1);
    chk32("b2b_second_rdata", rdata0, 32'h081);
    @(posedge clk);
    #1;
    chk1("b2b_done", rvalid0, 1'b0);

    // Reset in the response cycle discards it and clears all state
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 4'd0; wdata = 32'h3FF;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk1("mid_rst_pre_rvalid", rvalid0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_rvalid", rvalid0, 1'b0);
    chk1("mid_rst_gnt", gnt0, 1'b1);
    chk128("mid_rst_attr_direct", attr0, 128'h0);
    chk128("mid_rst_attr_shadow", attr1, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 4'd5, 32'h0, 1'b0); chk32("mid_rst_regwen1", rd0, 32'h1);
    access(1'b0, 4'd1, 32'h0, 1'b0); chk32("mid_rst_pad1", rd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
